// File: rtl/seg7_pkg.sv
// Shared glyph constants and nibble decoder for the multiplexed 7-segment driver.
// Glyph bit order is seg[6]=a .. seg[0]=g, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h01;
  localparam logic [6:0] SEG_1   = 7'h4F;
  localparam logic [6:0] SEG_2   = 7'h12;
  localparam logic [6:0] SEG_3   = 7'h06;
  localparam logic [6:0] SEG_4   = 7'h4C;
  localparam logic [6:0] SEG_5   = 7'h24;
  localparam logic [6:0] SEG_6   = 7'h20;
  localparam logic [6:0] SEG_7   = 7'h0F;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h04;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h60;
  localparam logic [6:0] SEG_C   = 7'h31;
  localparam logic [6:0] SEG_D   = 7'h42;
  localparam logic [6:0] SEG_E   = 7'h30;
  localparam logic [6:0] SEG_F   = 7'h38;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // BCD mode treats 10..15 as invalid and shows nothing for them.
  function automatic logic [6:0] nib2seg(input logic [3:0] nib, input logic hex_mode);
    logic [6:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      4'hF:    g = SEG_F;
      default: g = SEG_OFF;
    endcase
    return (!hex_mode && (nib > 4'd9)) ? SEG_OFF : g;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Data/display bundle between the digit producer (master) and the scan driver (slave).
interface seg7_scan_mux_if #(parameter int NDIG = 4);
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp;
  logic              load;
  logic              hex_mode;
  logic              lz_blank;
  logic [6:0]        seg;
  logic              dp_out;
  logic [NDIG-1:0]   an;
  logic              frame_tick;

  modport master (
    output digits, dp, load, hex_mode, lz_blank,
    input  seg, dp_out, an, frame_tick
  );

  modport slave (
    input  digits, dp, load, hex_mode, lz_blank,
    output seg, dp_out, an, frame_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder with a forced-blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over any glyph.
  always_comb begin
    seg_o = SEG_OFF;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      seg_o = nib2seg(nibble_i, hex_mode_i);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment scanner: prescaler, digit index, tear-free
// double buffer committed at frame wrap, leading-zero and anti-ghost blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int CLK_DIV = 4,
  parameter int BLANK   = 1
) (
  input  logic            clk,
  input  logic            clr,
  seg7_scan_mux_if.slave  bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d, pend_q, pend_d;
  logic [NDIG-1:0]   sdp_q, sdp_d, pdp_q, pdp_d;
  logic              pflag_q, pflag_d;
  logic [6:0]        seg_q, seg_d;
  logic              dpo_q, dpo_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              ft_q, ft_d;

  logic              slot_end_s, frame_end_s, blank_slot_s, lz_s;
  logic [3:0]        nib_s;
  logic [6:0]        glyph_s;

  assign slot_end_s   = (presc_q == PW'(CLK_DIV - 1));
  assign frame_end_s  = slot_end_s && (idx_q == IW'(NDIG - 1));
  assign blank_slot_s = (BLANK != 0) && slot_end_s;
  assign nib_s        = shadow_q[{idx_q, 2'b00} +: 4];
  // A digit is a leading zero when it and every more-significant nibble are zero.
  assign lz_s = bus.lz_blank && (idx_q != {IW{1'b0}}) &&
                ((shadow_q >> {idx_q, 2'b00}) == {(4*NDIG){1'b0}});

  seg7_decode u_decode (
    .nibble_i   (nib_s),
    .hex_mode_i (bus.hex_mode),
    .blank_i    (lz_s || blank_slot_s),
    .seg_o      (glyph_s)
  );

  // Scan counters and buffer hand-over; a load on the wrap cycle bypasses pending.
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    pend_d   = pend_q;
    pdp_d    = pdp_q;
    pflag_d  = pflag_q;
    if (slot_end_s) begin
      presc_d = {PW{1'b0}};
      idx_d   = frame_end_s ? {IW{1'b0}} : (idx_q + IW'(1));
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (frame_end_s) begin
      if (bus.load) begin
        shadow_d = bus.digits;
        sdp_d    = bus.dp;
      end else if (pflag_q) begin
        shadow_d = pend_q;
        sdp_d    = pdp_q;
      end else begin
        shadow_d = shadow_q;
      end
      pflag_d = 1'b0;
    end else if (bus.load) begin
      pend_d  = bus.digits;
      pdp_d   = bus.dp;
      pflag_d = 1'b1;
    end else begin
      pflag_d = pflag_q;
    end
  end

  // Display outputs for the slot currently addressed by idx/prescaler.
  always_comb begin
    an_d  = ANODE_OFF[NDIG-1:0];
    seg_d = glyph_s;
    dpo_d = 1'b1;
    ft_d  = frame_end_s;
    if (blank_slot_s) begin
      dpo_d = 1'b1;
    end else begin
      an_d[idx_q] = 1'b0;
      dpo_d       = ~sdp_q[idx_q];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q  <= {PW{1'b0}};
      idx_q    <= {IW{1'b0}};
      shadow_q <= {(4*NDIG){1'b0}};
      sdp_q    <= {NDIG{1'b0}};
      pend_q   <= {(4*NDIG){1'b0}};
      pdp_q    <= {NDIG{1'b0}};
      pflag_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      dpo_q    <= 1'b1;
      an_q     <= ANODE_OFF[NDIG-1:0];
      ft_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      pdp_q    <= pdp_d;
      pflag_q  <= pflag_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      an_q     <= an_d;
      ft_q     <= ft_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_out     = dpo_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench: two scanners (BLANK=0 and BLANK=1) against a cycle-count model.
module tb_seg7_scan_mux;
  localparam int NDIG = 4;
  localparam int CDIV = 4;
  localparam int FRAME = NDIG * CDIV;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b1;
  logic        lz_blank = 1'b0;

  int tests = 0;
  int fails = 0;

  seg7_scan_mux_if #(.NDIG(NDIG)) ifa ();
  seg7_scan_mux_if #(.NDIG(NDIG)) ifb ();

  assign ifa.digits = digits;   assign ifb.digits = digits;
  assign ifa.dp = dp;           assign ifb.dp = dp;
  assign ifa.load = load;       assign ifb.load = load;
  assign ifa.hex_mode = hex_mode; assign ifb.hex_mode = hex_mode;
  assign ifa.lz_blank = lz_blank; assign ifb.lz_blank = lz_blank;

  seg7_scan_mux #(.NDIG(NDIG), .CLK_DIV(CDIV), .BLANK(0)) dut0 (.clk(clk), .clr(clr), .bus(ifa));
  seg7_scan_mux #(.NDIG(NDIG), .CLK_DIV(CDIV), .BLANK(1)) dut1 (.clk(clk), .clr(clr), .bus(ifb));

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model: m_n = clock edges since reset release; display derived from it arithmetically.
  int          m_n = 0;
  logic [15:0] m_sh = 16'h0000, m_pend = 16'h0000;
  logic [3:0]  m_sdp = 4'h0, m_pdp = 4'h0;
  bit          m_flag = 1'b0;
  logic [12:0] exp0 = {7'h7F, 4'hF, 1'b1, 1'b0};
  logic [12:0] exp1 = {7'h7F, 4'hF, 1'b1, 1'b0};

  function automatic logic [11:0] disp(input int n, input logic [15:0] sh, input logic [3:0] sdp,
                                       input bit blank_en, input logic hx, input logic lz);
    int slot, d;
    logic [15:0] upper;
    logic [3:0] nib;
    logic [6:0] s;
    logic [3:0] a;
    slot = n % CDIV;
    d = (n / CDIV) % NDIG;
    if (blank_en && slot == CDIV - 1) return {7'h7F, 4'hF, 1'b1};
    upper = sh >> (4 * d);
    nib = upper[3:0];
    if (lz && d > 0 && upper == 16'h0000) s = 7'h7F;
    else if (!hx && nib > 4'd9) s = 7'h7F;
    else s = glyph[nib];
    a = 4'hF & ~(4'h1 << d);
    return {s, a, ~sdp[d]};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (clr) begin
        m_n = 0; m_sh = 16'h0; m_pend = 16'h0; m_sdp = 4'h0; m_pdp = 4'h0; m_flag = 1'b0;
        exp0 = {7'h7F, 4'hF, 1'b1, 1'b0};
        exp1 = exp0;
      end else begin
        bit bnd;
        bnd = ((m_n + 1) % FRAME) == 0;
        exp0 = {disp(m_n, m_sh, m_sdp, 1'b0, hex_mode, lz_blank), bnd};
        exp1 = {disp(m_n, m_sh, m_sdp, 1'b1, hex_mode, lz_blank), bnd};
        if (bnd) begin
          if (load) begin m_sh = digits; m_sdp = dp; end
          else if (m_flag) begin m_sh = m_pend; m_sdp = m_pdp; end
          m_flag = 1'b0;
        end else if (load) begin
          m_pend = digits; m_pdp = dp; m_flag = 1'b1;
        end
        m_n = m_n + 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      logic [12:0] g0, g1, e0, e1;
      @(negedge clk);
      g0 = {ifa.seg, ifa.an, ifa.dp_out, ifa.frame_tick};
      g1 = {ifb.seg, ifb.an, ifb.dp_out, ifb.frame_tick};
      e0 = clr ? {7'h7F, 4'hF, 1'b1, 1'b0} : exp0;
      e1 = clr ? {7'h7F, 4'hF, 1'b1, 1'b0} : exp1;
      tests++;
      if (g0 !== e0) begin
        fails++;
        if (fails < 30) $display("FAIL cmp_blank0 t=%0t got seg/an/dp/ft=%h expected %h", $time, g0, e0);
      end
      tests++;
      if (g1 !== e1) begin
        fails++;
        if (fails < 30) $display("FAIL cmp_blank1 t=%0t got seg/an/dp/ft=%h expected %h", $time, g1, e1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic wait_ft(input string name);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (!ifa.frame_tick && c < 3 * FRAME);
    chk(name, {31'd0, ifa.frame_tick}, 32'd1);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    digits = d; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_slot(input string name, input logic [3:0] an_e, input logic [6:0] seg_e);
    chk(name, {21'd0, ifa.an, ifa.seg}, {21'd0, an_e, seg_e});
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2 clr = 1'b1;
    #1 chk("reset_immediate", {19'd0, ifa.seg, ifa.an, ifa.dp_out, ifa.frame_tick},
           {19'd0, 7'h7F, 4'hF, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #2 clr = 1'b0;
  endtask

  initial begin
    int cnt;
    @(negedge clk);
    chk("reset_state", {19'd0, ifa.seg, ifa.an, ifa.dp_out, ifa.frame_tick},
        {19'd0, 7'h7F, 4'hF, 1'b1, 1'b0});
    @(posedge clk); #2 clr = 1'b0;
    repeat (6) @(negedge clk);
    pulse_clr();

    // Scan order and frame period.
    @(negedge clk);
    pulse_load(16'h0123, 4'h0);
    wait_ft("scan_ft");
    @(negedge clk); chk_slot("scan_d0", 4'hE, 7'h06);
    repeat (4) @(negedge clk); chk_slot("scan_d1", 4'hD, 7'h12);
    repeat (4) @(negedge clk); chk_slot("scan_d2", 4'hB, 7'h4F);
    repeat (4) @(negedge clk); chk_slot("scan_d3", 4'h7, 7'h01);
    cnt = 13;
    do begin @(negedge clk); cnt++; end while (!ifa.frame_tick && cnt < 40);
    chk("ft_period", cnt, 32'd16);

    // Mid-frame load stays hidden until the next wrap.
    repeat (6) @(negedge clk);
    pulse_load(16'h9876, 4'h0);
    repeat (2) @(negedge clk); chk_slot("tear_old_d2", 4'hB, 7'h4F);
    wait_ft("tear_ft");
    @(negedge clk); chk_slot("tear_d0", 4'hE, 7'h20);
    repeat (4) @(negedge clk); chk_slot("tear_d1", 4'hD, 7'h0F);
    repeat (4) @(negedge clk); chk_slot("tear_d2", 4'hB, 7'h00);
    repeat (4) @(negedge clk); chk_slot("tear_d3", 4'h7, 7'h04);

    // Load on the exact wrap cycle is shown in the frame that follows.
    repeat (2) @(negedge clk);
    pulse_load(16'h4321, 4'h0);
    chk("bnd_ft", {31'd0, ifa.frame_tick}, 32'd1);
    @(negedge clk); chk_slot("bnd_d0", 4'hE, 7'h4F);
    repeat (4) @(negedge clk); chk_slot("bnd_d1", 4'hD, 7'h12);

    // Hex/BCD and leading-zero blanking.
    lz_blank = 1'b1;
    pulse_load(16'h00AF, 4'h0);
    wait_ft("mode_ft");
    @(negedge clk); chk_slot("hex_d0", 4'hE, 7'h38);
    repeat (4) @(negedge clk); chk_slot("hex_d1", 4'hD, 7'h08);
    repeat (4) @(negedge clk); chk_slot("lz_d2", 4'hB, 7'h7F);
    repeat (4) @(negedge clk); chk_slot("lz_d3", 4'h7, 7'h7F);
    hex_mode = 1'b0;
    wait_ft("bcd_ft");
    @(negedge clk); chk_slot("bcd_d0", 4'hE, 7'h7F);
    repeat (4) @(negedge clk); chk_slot("bcd_d1", 4'hD, 7'h7F);
    hex_mode = 1'b1;
    pulse_load(16'h0000, 4'h0);
    wait_ft("zero_ft");
    @(negedge clk); chk_slot("zero_d0", 4'hE, 7'h01);
    repeat (4) @(negedge clk); chk_slot("zero_d1", 4'hD, 7'h7F);

    // Decimal point and anti-ghost blanking slot.
    lz_blank = 1'b0;
    pulse_load(16'h1234, 4'b0100);
    wait_ft("dp_ft");
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 4)  chk("blank_slot", {20'd0, ifb.an, ifb.seg, ifb.dp_out}, {20'd0, 4'hF, 7'h7F, 1'b1});
      if (k == 10) chk("dp_lit", {20'd0, ifb.an, ifb.seg, ifb.dp_out}, {20'd0, 4'hB, 7'h12, 1'b0});
      if (k == 12) chk("dp_blank", {27'd0, ifb.an, ifb.dp_out}, {27'd0, 4'hF, 1'b1});
      if (k == 12) chk("dp_noblank", {27'd0, ifa.an, ifa.dp_out}, {27'd0, 4'hB, 1'b0});
      if (k == 13) chk("dp_off_d3", {27'd0, ifb.an, ifb.dp_out}, {27'd0, 4'h7, 1'b1});
    end

    // Reset with a load pending discards it.
    repeat (3) @(negedge clk);
    pulse_load(16'h5555, 4'hF);
    pulse_clr();
    wait_ft("rst_ft");
    @(negedge clk);
    chk("rst_d0", {20'd0, ifa.an, ifa.seg, ifa.dp_out}, {20'd0, 4'hE, 7'h01, 1'b1});
    repeat (4) @(negedge clk); chk_slot("rst_d1", 4'hD, 7'h01);
    repeat (FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
